shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
Round-robin scheduler that shares one 32-bit logical barrel-shift unit among N_REQ requesters. Each requester issues a valid/ready shift request. Each granted request is shifted and the result is registered into a single-entry output stage, tagged with the requester ID. Full throughput is one operation per cycle; latency is 1 cycle. The block sits between the shift requesters (decode/ALU-side clients) and their result consumer.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width (fixed at 32)
AMT_W, 5, shift-amount width, equal to log2(DATA_W)
ID_W, 2, requester-ID width, equal to ceil(log2(N_REQ)); derived and not overridden

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_data  in  N_REQ*DATA_W  operands, requester i at bits [i*32 +: 32]
req_amt  in  N_REQ*AMT_W  shift amounts, requester i at [i*5 +: 5]
req_dir  in  N_REQ  0 = left, 1 = right (logical, zero fill)
resp_valid  out  1  result valid
resp_ready  in  1  consumer accept
resp_data  out  DATA_W  shifted result
resp_id  out  ID_W  index of the requester that produced resp_data
op_count  out  16  accepted-operation counter, wraps at 2^16

Behaviour:
- Reset (async, active-high): resp_valid=0, resp_data=0, resp_id=0, op_count=0, rr_ptr=0. req_ready is 0 while rst is high.
- can_accept = !resp_valid || resp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping at N_REQ-1 to 0.
  - The first valid index found is the grant g.
  - req_ready[g] = can_accept. All other req_ready bits = 0.
  - If no request is valid, req_ready = 0.
- Grants are not sticky. A requester must hold valid/data/amt/dir stable until its ready is seen; it must not drop valid before acceptance.
- Accept at edge k (req_valid[g] && req_ready[g]):
  - resp_data <= shift(req_data[g], req_amt[g], req_dir[g])
  - resp_id <= g
  - resp_valid <= 1
  - rr_ptr <= (g+1) mod N_REQ
  - op_count <= op_count+1
- Result is visible after edge k (1-cycle latency).
- Drain without accept (resp_valid && resp_ready, no grant): resp_valid <= 0. resp_data and resp_id hold their values.
- Simultaneous drain and accept: the new result replaces the old one; resp_valid stays 1 (back-to-back, no bubble).
- Backpressure (resp_valid && !resp_ready): req_ready = 0. Output registers, rr_ptr and op_count hold.
- Shift rules:
  - amt=0 passes data through unchanged.
  - Left shift: data<<amt, low bits zero-filled.
  - Right shift: data>>amt, high bits zero-filled.
  - The result is truncated to 32 bits.
- State machine (output stage), 2 states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain with no accept.
  - FULL -> FULL on backpressure or on drain+accept.
- op_count wraps 0xFFFF -> 0x0000.
- Reset mid-operation: the pending result is discarded immediately, with no resp_valid glitch after reset release.

Optional Feature:
Macro SHIFT_SCHED_ROTATE_EN.
- Defined:
  - Adds input port req_rot (N_REQ bits).
  - req_rot[i]=1 selects rotate in direction req_dir[i]: bits shifted out re-enter at the opposite end.
  - amt=0 still passes data through.
- Undefined:
  - Port req_rot is absent.
  - All operations are logical shifts as above.

Decomposition:
- Package shift_sched_pkg:
  - DATA_W, AMT_W constants
  - Direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - Output-state enum {ST_EMPTY, ST_FULL}
  - Function shift_op(data, amt, dir[, rot])
- Sub-module rr_arbiter (N_REQ): inputs req and ptr; outputs one-hot grant and index. Reused by other shared-resource schedulers.
- The shift datapath stays inline via the package function.

Test Plan:
- Single request, left shift: requester 0 sends data=0x0000_00F0, amt=4, dir=0, resp_ready=1 -> one cycle later resp_valid=1, resp_data=0x0000_0F00, resp_id=0, op_count=1.
- Right shift with zero fill, boundary amounts: data=0x8000_0001, amt=31, dir=1 -> 0x0000_0001. amt=0 -> 0x8000_0001. amt=31 left -> 0x8000_0000.
- Round-robin fairness: all 4 requesters held valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1,… at 1 result per cycle; no requester granted twice before the others.
- Backpressure: resp_ready=0 for 3 cycles while FULL -> req_ready=0, resp_data and resp_id stable, op_count unchanged. Releasing resp_ready gives drain+accept in the same cycle with no bubble.
- Async reset mid-stream: assert rst between edges while FULL -> resp_valid=0, resp_data=0, op_count=0 immediately. After release, the next grant starts at requester 0.
- Rotate (SHIFT_SCHED_ROTATE_EN defined): data=0x8000_0001, amt=1, dir=0, rot=1 -> 0x0000_0003. Same with dir=1 -> 0xC000_0000.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared constants, output-stage state type and the shift/rotate datapath function
// for the shift_sched round-robin shift scheduler.
package shift_sched_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned CNT_W  = 16;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Logical shift (zero fill) or rotate; rotate uses a doubled word so wrapped bits fall in
  function automatic logic [DATA_W-1:0] shift_op(
    input logic [DATA_W-1:0] data,
    input logic [AMT_W-1:0]  amt,
    input logic              dir,
    input logic              rot
  );
    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   res;
    dbl = {data, data};
    if (rot) begin
      if (dir == DIR_LEFT) begin
        dbl = dbl << amt;
        res = dbl[2*DATA_W-1:DATA_W];
      end else begin
        dbl = dbl >> amt;
        res = dbl[DATA_W-1:0];
      end
    end else begin
      res = (dir == DIR_LEFT) ? (data << amt) : (data >> amt);
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping at N_REQ-1.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // Circular priority search starting at the pointer
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one 32-bit barrel shifter among N_REQ requesters,
// with a single-entry registered result stage tagged by requester ID.
// Optional rotate support is enabled by defining SHIFT_SCHED_ROTATE_EN (adds req_rot).
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*AMT_W-1:0]  req_amt,
  input  logic [N_REQ-1:0]        req_dir,
`ifdef SHIFT_SCHED_ROTATE_EN
  input  logic [N_REQ-1:0]        req_rot,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] resp_id,
  output logic [CNT_W-1:0]        op_count
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              can_accept;
  logic              accept;
  logic              sel_rot;

  logic [DATA_W-1:0] opnd    [N_REQ];
  logic [AMT_W-1:0]  amt_arr [N_REQ];

  // Unpack flattened per-requester operand buses
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign opnd[gi]    = req_data[gi*DATA_W +: DATA_W];
    assign amt_arr[gi] = req_amt[gi*AMT_W +: AMT_W];
  end

`ifdef SHIFT_SCHED_ROTATE_EN
  assign sel_rot = req_rot[arb_idx];
`else
  assign sel_rot = 1'b0;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  // Output-stage state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state: fill on accept, empty on drain without a replacement
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (resp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs: the slot is free when empty or being drained this cycle
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || resp_ready;
    accept     = arb_any && can_accept && !rst;
    req_ready  = accept ? arb_grant : '0;
    resp_valid = (state_q == ST_FULL);
  end

  // Result, tag, pointer and counter update on accept; hold otherwise
  always_comb begin
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q;
    if (accept) begin
      resp_data_d = shift_op(opnd[arb_idx], amt_arr[arb_idx], req_dir[arb_idx], sel_rot);
      resp_id_d   = arb_idx;
      rr_ptr_d    = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
      op_count_d  = op_count_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q <= '0;
      resp_id_q   <= '0;
      rr_ptr_q    <= '0;
      op_count_q  <= '0;
    end else begin
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_id   = resp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_sched.sv
// Testbench for shift_sched: directed scenarios plus randomized traffic checked
// against a transaction-level reference model (arithmetic shift/rotate, circular search).
module tb_shift_sched;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_data;
  logic [N*5-1:0]  req_amt;
  logic [N-1:0]    req_dir;
  logic [N-1:0]    req_rot;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [1:0]      resp_id;
  logic [15:0]     op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  int          m_cnt;
  int          m_ptr;
  int          last_g;

  shift_sched #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_dir    (req_dir),
`ifdef SHIFT_SCHED_ROTATE_EN
    .req_rot    (req_rot),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift/rotate by multiplying/dividing by 2**amt
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                            input logic dir, input logic rot);
    longint unsigned dd, p, prod, res;
    dd = 64'(d);
    p  = 64'(1) << amt;
    if (dir == 1'b0) begin
      prod = dd * p;
      res  = prod % 64'h1_0000_0000;
      if (rot) res = res + prod / 64'h1_0000_0000;
    end else begin
      res = dd / p;
      if (rot) res = res + (dd % p) * (64'h1_0000_0000 / p);
    end
    return 32'(res);
  endfunction

  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g = model_grant();
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = 0; m_ptr = 0; last_g = -1;
  endtask

  // Advance one clock edge and update the model from the inputs present at that edge
  task automatic tick();
    int g;
    g = model_grant();
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      m_data  = ref_shift(req_data[g*32 +: 32], int'(req_amt[g*5 +: 5]), req_dir[g], req_rot[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (m_valid && resp_ready && !rst) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input int amt,
                         input logic dir, input logic rot);
    req_data[i*32 +: 32] = d;
    req_amt[i*5 +: 5]    = 5'(amt);
    req_dir[i]           = dir;
    req_rot[i]           = rot;
  endtask

  task automatic randomize_req(input int i);
    logic r;
    r = 1'b0;
`ifdef SHIFT_SCHED_ROTATE_EN
    r = 1'($urandom_range(0, 1));
`endif
    set_req(i, $urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
    req_data = '0; req_amt = '0; req_dir = '0; req_rot = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", resp_valid); end
    n_tests++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", resp_data); end
    n_tests++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", resp_id); end
    n_tests++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", op_count); end
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single_left();
    set_req(0, 32'h0000_00F0, 4, 1'b0, 1'b0);
    req_valid = 4'b0001; resp_ready = 1'b1; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", resp_valid); end
    n_tests++; if (resp_data !== 32'h0000_0F00) begin n_fail++; $display("FAIL single_data: got %h want 00000f00", resp_data); end
    n_tests++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", resp_id); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", op_count); end
    tick();
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0b want 0", resp_valid); end
    n_tests++; if (resp_data !== 32'h0000_0F00) begin n_fail++; $display("FAIL drain_hold: got %h want 00000f00", resp_data); end
  endtask

  task automatic test_boundary();
    logic [31:0] t_data [3] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
    int          t_amt  [3] = '{31, 0, 31};
    logic        t_dir  [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] t_exp  [3] = '{32'h0000_0001, 32'h8000_0001, 32'h8000_0000};
    resp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(2, t_data[t], t_amt[t], t_dir[t], 1'b0);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      n_tests++; if (resp_data !== t_exp[t]) begin n_fail++; $display("FAIL boundary_%0d: got %h want %h", t, resp_data, t_exp[t]); end
      n_tests++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL boundary_id_%0d: got %0d want 2", t, resp_id); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) randomize_req(i);
    req_valid = '1; resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++; if (resp_id !== 2'(c % N) || resp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_seq_%0d: got id %0d valid %0b want id %0d valid 1", c, resp_id, resp_valid, c % N); end
      n_tests++; if (resp_data !== m_data) begin n_fail++; $display("FAIL rr_data_%0d: got %h want %h", c, resp_data, m_data); end
      n_tests++; if (op_count !== 16'(c + 1)) begin n_fail++; $display("FAIL rr_count_%0d: got %0d want %0d", c, op_count, c + 1); end
      if (last_g >= 0) randomize_req(last_g);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h_data;
    logic [1:0]  h_id;
    logic [15:0] h_cnt;
    req_valid = '1; resp_ready = 1'b1;
    tick();
    randomize_req(last_g);
    h_data = m_data; h_id = 2'(m_id); h_cnt = 16'(m_cnt);
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 0000", c, req_ready); end
      tick();
      n_tests++; if (resp_valid !== 1'b1 || resp_data !== h_data || resp_id !== h_id || op_count !== h_cnt) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v%0b %h id%0d cnt%0d want v1 %h id%0d cnt%0d", c, resp_valid, resp_data, resp_id, op_count, h_data, h_id, h_cnt);
      end
    end
    resp_ready = 1'b1; #1;
    n_tests++; if (req_ready !== N'(1 << ((int'(h_id) + 1) % N))) begin n_fail++; $display("FAIL bp_release_ready: got %b want %b", req_ready, N'(1 << ((int'(h_id) + 1) % N))); end
    tick();
    randomize_req(last_g);
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'((int'(h_id) + 1) % N) || op_count !== h_cnt + 16'd1) begin
      n_fail++; $display("FAIL bp_no_bubble: got v%0b id%0d cnt%0d want v1 id%0d cnt%0d", resp_valid, resp_id, op_count, (int'(h_id) + 1) % N, h_cnt + 16'd1);
    end
    n_tests++; if (resp_data !== m_data) begin n_fail++; $display("FAIL bp_data: got %h want %h", resp_data, m_data); end
  endtask

  task automatic test_async_reset();
    req_valid = '1; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_tests++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || op_count !== 16'h0 || req_ready !== 4'b0) begin
      n_fail++; $display("FAIL areset: got v%0b %h cnt%0d rdy%b want v0 0 cnt0 rdy0000", resp_valid, resp_data, op_count, req_ready);
    end
    model_reset();
    tick(); tick();
    rst = 1'b0; #1;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release: got %0b want 0", resp_valid); end
    resp_ready = 1'b1;
    tick();
    randomize_req(last_g);
    n_tests++; if (resp_id !== 2'd0 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL areset_first: got id%0d v%0b want id0 v1", resp_id, resp_valid); end
    n_tests++; if (resp_data !== m_data) begin n_fail++; $display("FAIL areset_data: got %h want %h", resp_data, m_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || i == last_g) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          randomize_req(i);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready_%0d: got %b want %b", c, req_ready, exp_ready()); end
      tick();
      n_tests++; if (resp_valid !== m_valid || op_count !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_state_%0d: got v%0b cnt%0d want v%0b cnt%0d", c, resp_valid, op_count, m_valid, m_cnt);
      end
      if (m_valid) begin
        n_tests++; if (resp_data !== m_data || resp_id !== 2'(m_id)) begin
          n_fail++; $display("FAIL rand_result_%0d: got %h id%0d want %h id%0d", c, resp_data, resp_id, m_data, m_id);
        end
      end
    end
  endtask

`ifdef SHIFT_SCHED_ROTATE_EN
  task automatic test_rotate();
    logic        r_dir [2] = '{1'b0, 1'b1};
    logic [31:0] r_exp [2] = '{32'h0000_0003, 32'hC000_0000};
    req_valid = '0; resp_ready = 1'b1;
    tick(); tick();
    for (int t = 0; t < 2; t++) begin
      set_req(1, 32'h8000_0001, 1, r_dir[t], 1'b1);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      n_tests++; if (resp_data !== r_exp[t]) begin n_fail++; $display("FAIL rotate_%0d: got %h want %h", t, resp_data, r_exp[t]); end
      tick();
    end
    set_req(1, 32'h8000_0001, 0, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    n_tests++; if (resp_data !== 32'h8000_0001) begin n_fail++; $display("FAIL rotate_amt0: got %h want 80000001", resp_data); end
    tick();
  endtask
`endif

  task automatic test_wrap();
    int budget;
    budget = 70000;
    req_valid = '1; resp_ready = 1'b1;
    while (m_cnt != 65535 && budget > 0) begin
      tick();
      budget--;
    end
    n_tests++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffff", op_count); end
    tick();
    n_tests++; if (op_count !== 16'h0000 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got %h v%0b want 0000 v1", op_count, resp_valid); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_random();
`ifdef SHIFT_SCHED_ROTATE_EN
    test_rotate();
`endif
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
